backprop_delta_unit: RTL and testbench

// - Downstream consumer of the backprop pipeline register.
// - Converts each lane's incoming error into the layer delta: delta[i] = err[i] * act'(z[i]).
// - Uses one shared saturating fixed-point multiplier, stepped lane by lane.
// - Valid/ready on both sides; feeds the weight-gradient stage.

---
 rtl/backprop_pkg.sv | 23 ++
 rtl/fxp_mul_sat.sv | 34 +++
 rtl/backprop_delta_unit.sv | 189 ++++++++++++++++++
 tb/tb_backprop_delta_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/backprop_pkg.sv
// Shared definitions for the backprop delta stage: activation codes,
// control-word field positions and the sequencer state encoding.
package backprop_pkg;

    // Activation selector values carried in the low control bits.
    localparam logic [3:0] ACT_LINEAR  = 4'd0;
    localparam logic [3:0] ACT_RELU    = 4'd1;
    localparam logic [3:0] ACT_LEAKY   = 4'd2;
    localparam logic [3:0] ACT_SIGMOID = 4'd3;

    // Control word layout: [3:0] act_type, [4] src_sel, remaining bits opaque.
    localparam int ACT_LSB     = 0;
    localparam int ACT_W       = 4;
    localparam int SRC_SEL_BIT = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply with rounding toward minus infinity and
// saturation back to data_size bits. Operands are one bit wider than a
// lane so that (ONE - p) is represented exactly for every lane value p.
module fxp_mul_sat #(
    parameter int data_size = 16,
    parameter int frac_bits = 8
) (
    input  logic signed [data_size:0]   a_i,
    input  logic signed [data_size:0]   b_i,
    output logic signed [data_size-1:0] p_o
);

    localparam int PW = 2 * (data_size + 1);

    localparam logic signed [PW-1:0] MAX_V = {{(PW-data_size+1){1'b0}}, {(data_size-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(PW-data_size+1){1'b1}}, {(data_size-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    // Full-width product, rescale by the fractional bits, clamp to lane range.
    always_comb begin
        prod    = a_i * b_i;
        shifted = prod >>> frac_bits;
        if (shifted > MAX_V) begin
            p_o = MAX_V[data_size-1:0];
        end else if (shifted < MIN_V) begin
            p_o = MIN_V[data_size-1:0];
        end else begin
            p_o = shifted[data_size-1:0];
        end
    end

endmodule

// File: rtl/backprop_delta_unit.sv
// Backprop delta stage: captures one bus of errors, pre-activations and
// activations, then walks the lanes in order computing
// delta[i] = err[i] * act'(z[i]) through a single shared multiplier.
// One extra commit cycle moves the finished lanes into the output
// registers, giving size+1 (or 2*size+1 for sigmoid) cycles of latency.
module backprop_delta_unit
    import backprop_pkg::*;
#(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int frac_bits              = 8,
    parameter int backprop_controll_size = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [size*data_size-1:0]         diff_to_all,
    input  logic [size*data_size-1:0]         diff_cost,
    input  logic [size*data_size-1:0]         z,
    input  logic [size*data_size-1:0]         predict_value,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [size*data_size-1:0]         delta_out,
    output logic [size*data_size-1:0]         z_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out,
    output logic                              bad_type
);

    localparam int CNT_W = (size > 1) ? $clog2(size) : 1;
    localparam int MW    = data_size + 1;

    localparam logic [CNT_W-1:0]     LAST_LANE = CNT_W'(size - 1);
    localparam logic signed [MW-1:0] ONE_X     = MW'(1) << frac_bits;

    // Sequencer and captured transaction.
    state_e                                 state_q;
    logic [CNT_W-1:0]                       lane_cnt_q;
    logic                                   phase_q;
    logic                                   last_q;
    logic [size-1:0][data_size-1:0]         err_q;
    logic [size-1:0][data_size-1:0]         z_q;
    logic [size-1:0][data_size-1:0]         p_q;
    logic [backprop_controll_size-1:0]      ctrl_q;
    logic signed [data_size-1:0]            d_q;
    logic [size-1:0][data_size-1:0]         work_q;

    // Registered outputs.
    logic                                   in_ready_q;
    logic                                   out_valid_q;
    logic                                   bad_type_q;
    logic [size-1:0][data_size-1:0]         delta_out_q;
    logic [size-1:0][data_size-1:0]         z_out_q;
    logic [backprop_controll_size-1:0]      ctrl_out_q;

    // Per-lane datapath.
    logic [3:0]                             act;
    logic                                   is_sig;
    logic                                   is_bad;
    logic                                   z_pos;
    logic signed [data_size-1:0]            err_l;
    logic signed [data_size-1:0]            z_l;
    logic signed [data_size-1:0]            p_l;
    logic signed [MW-1:0]                   mul_a;
    logic signed [MW-1:0]                   mul_b;
    logic signed [data_size-1:0]            mul_res;
    logic signed [data_size-1:0]            lane_res;

    // Decode the captured control word and pick multiplier operands for the current lane/phase.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can infer a latch.
        act    = ctrl_q[ACT_LSB +: ACT_W];
        is_sig = (act == ACT_SIGMOID);
        is_bad = (act > ACT_SIGMOID);
        err_l  = err_q[lane_cnt_q];
        z_l    = z_q[lane_cnt_q];
        p_l    = p_q[lane_cnt_q];
        z_pos  = !z_l[data_size-1] && (z_l != '0);
        mul_a  = {p_l[data_size-1], p_l};
        mul_b  = ONE_X - {p_l[data_size-1], p_l};
        if (phase_q) begin
            mul_a = {err_l[data_size-1], err_l};
            mul_b = {d_q[data_size-1], d_q};
        end
    end

    // Shared multiplier: phase A forms p*(ONE-p), phase B forms err*d.
    fxp_mul_sat #(
        .data_size (data_size),
        .frac_bits (frac_bits)
    ) u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_res)
    );

    // Select the finished delta for the current lane according to the activation.
    always_comb begin
        lane_res = '0;
        case (act)
            ACT_LINEAR:  lane_res = err_l;
            ACT_RELU:    lane_res = z_pos ? err_l : '0;
            ACT_LEAKY:   lane_res = z_pos ? err_l : (err_l >>> 3);
            ACT_SIGMOID: lane_res = mul_res;
            default:     lane_res = '0;
        endcase
    end

    // Sequencer: capture in IDLE, step lanes in CALC, commit and hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: capture and working registers are reset along with the outputs so an
        // aborted transaction leaves nothing behind that could leak into a later result.
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_cnt_q  <= '0;
            phase_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= '0;
            z_q         <= '0;
            p_q         <= '0;
            ctrl_q      <= '0;
            d_q         <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bad_type_q  <= 1'b0;
            delta_out_q <= '0;
            z_out_q     <= '0;
            ctrl_out_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        err_q      <= backprop_controll[SRC_SEL_BIT] ? diff_cost : diff_to_all;
                        z_q        <= z;
                        p_q        <= predict_value;
                        ctrl_q     <= backprop_controll;
                        lane_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        last_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (last_q) begin
                        delta_out_q <= work_q;
                        z_out_q     <= z_q;
                        ctrl_out_q  <= ctrl_q;
                        bad_type_q  <= is_bad;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (is_sig && !phase_q) begin
                        d_q     <= mul_res;
                        phase_q <= 1'b1;
                    end else begin
                        work_q[lane_cnt_q] <= lane_res;
                        phase_q            <= 1'b0;
                        if (lane_cnt_q == LAST_LANE) begin
                            last_q <= 1'b1;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready              = in_ready_q;
    assign out_valid             = out_valid_q;
    assign bad_type              = bad_type_q;
    assign delta_out             = delta_out_q;
    assign z_out                 = z_out_q;
    assign backprop_controll_out = ctrl_out_q;

endmodule

// File: tb/tb_backprop_delta_unit.sv
// Directed bench for backprop_delta_unit. The driver issues transactions and
// pushes hand-computed expectations into a scoreboard queue; an independent
// monitor compares every cycle the DUT presents out_valid.
module tb_backprop_delta_unit;

    localparam int SIZE = 3;
    localparam int DW   = 16;
    localparam int FB   = 8;
    localparam int CW   = 100;
    localparam int BW   = SIZE * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] diff_to_all = '0;
    logic [BW-1:0] diff_cost = '0;
    logic [BW-1:0] z = '0;
    logic [BW-1:0] predict_value = '0;
    logic [CW-1:0] backprop_controll = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] delta_out;
    logic [BW-1:0] z_out;
    logic [CW-1:0] backprop_controll_out;
    logic          bad_type;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            id;
        logic [BW-1:0] delta;
        logic [BW-1:0] z;
        logic [CW-1:0] ctrl;
        logic          bad;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];

    backprop_delta_unit #(
        .size                   (SIZE),
        .data_size              (DW),
        .frac_bits              (FB),
        .backprop_controll_size (CW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .diff_to_all           (diff_to_all),
        .diff_cost             (diff_cost),
        .z                     (z),
        .predict_value         (predict_value),
        .backprop_controll     (backprop_controll),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .delta_out             (delta_out),
        .z_out                 (z_out),
        .backprop_controll_out (backprop_controll_out),
        .bad_type              (bad_type)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk_ctrl(input int id, input logic src, input logic [3:0] act);
        logic [CW-6:0] opq;
        opq = {31'(id * 7 + 1), 32'hDEAD_0000 + 32'(id), 32'hC0DE_5A5A ^ 32'(id)};
        return {opq, src, act};
    endfunction

    // Present one transaction, wait (bounded) for acceptance, record the expectation,
    // then scramble the buses so any late sampling by the DUT is exposed.
    task automatic send(input int id, input logic [3:0] act, input logic src,
                        input logic [BW-1:0] dta, input logic [BW-1:0] dc,
                        input logic [BW-1:0] zz, input logic [BW-1:0] pp,
                        input logic [BW-1:0] exp_delta, input logic exp_bad,
                        input int exp_lat, output int waits);
        exp_t          e;
        logic [CW-1:0] ctl;
        ctl               = mk_ctrl(id, src, act);
        diff_to_all       = dta;
        diff_cost         = dc;
        z                 = zz;
        predict_value     = pp;
        backprop_controll = ctl;
        in_valid          = 1'b1;
        waits             = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check($sformatf("t%0d_accept_timeout", id), in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        e.id    = id;
        e.delta = exp_delta;
        e.z     = zz;
        e.ctrl  = ctl;
        e.bad   = exp_bad;
        e.lat   = exp_lat;
        e.acc   = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid          = 1'b0;
        diff_to_all       = ~dta;
        diff_cost         = ~dc;
        z                 = ~zz;
        predict_value     = ~pp;
        backprop_controll = ~ctl;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    initial begin
        exp_t cur;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_out_valid", out_valid, 1'b0);
                    end else begin
                        cur = sb[0];
                        if (!prev_valid) begin
                            check($sformatf("t%0d_latency", cur.id), cyc - cur.acc - 1, cur.lat);
                        end
                        check($sformatf("t%0d_delta", cur.id), delta_out, cur.delta);
                        check($sformatf("t%0d_z_out", cur.id), z_out, cur.z);
                        check($sformatf("t%0d_ctrl_out", cur.id), backprop_controll_out, cur.ctrl);
                        check($sformatf("t%0d_bad_type", cur.id), bad_type, cur.bad);
                        check($sformatf("t%0d_in_ready_busy", cur.id), in_ready, 1'b0);
                        if (out_ready) begin
                            void'(sb.pop_front());
                        end
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    // Driver.
    initial begin
        int w;
        int n;

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_delta", delta_out, '0);
        check("rst_z_out", z_out, '0);
        check("rst_ctrl_out", backprop_controll_out, '0);
        check("rst_bad_type", bad_type, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // RELU: lane0 z>0 passes err, lane1 z=0 and lane2 z<0 give 0.
        send(1, 4'd1, 1'b0, {3{16'h0200}}, {3{16'h7777}},
             {16'hFF00, 16'h0000, 16'h0100}, '0,
             {16'h0000, 16'h0000, 16'h0200}, 1'b0, 4, w);
        // SIGMOID: p=0.5 -> d=0.25, err=1.0 -> 0x0040 each lane.
        send(2, 4'd3, 1'b1, {3{16'h1234}}, {3{16'h0100}},
             {16'h0011, 16'h0022, 16'h0033}, {3{16'h0080}},
             {3{16'h0040}}, 1'b0, 7, w);
        // LEAKY: negative z shifts err by 3 (arithmetic), positive z passes.
        send(3, 4'd2, 1'b0, {16'hFFF0, 16'h8000, 16'h0100}, '0,
             {16'hFF00, 16'h0005, 16'hFF00}, '0,
             {16'hFFFE, 16'h8000, 16'h0020}, 1'b0, 4, w);
        // SIGMOID saturation: p=0xF000 clamps d to 0x8000; p=ONE gives 0; p=0.25 gives 0x0060 with err=2.
        send(4, 4'd3, 1'b1, '0, {16'h0200, 16'h0100, 16'h0100},
             {16'h0001, 16'h0002, 16'h0003}, {16'h0040, 16'h0100, 16'hF000},
             {16'h0060, 16'h0000, 16'h8000}, 1'b0, 7, w);
        // LINEAR from diff_cost, extreme values pass unchanged.
        send(5, 4'd0, 1'b1, {3{16'h1111}}, {16'h8000, 16'h7FFF, 16'h0001},
             {16'h0100, 16'hFF00, 16'h0000}, '0,
             {16'h8000, 16'h7FFF, 16'h0001}, 1'b0, 4, w);
        // Unsupported act_type.
        send(6, 4'hF, 1'b0, {16'h1234, 16'h5678, 16'h9ABC}, '0,
             {16'hAAAA, 16'h5555, 16'h0F0F}, '0,
             '0, 1'b1, 4, w);
        wait_drain("drain_basic");

        // Backpressure: hold out_ready low while inputs churn.
        out_ready = 1'b0;
        send(7, 4'd0, 1'b0, {16'h0003, 16'h0002, 16'h0001}, '0,
             {16'h0030, 16'h0020, 16'h0010}, '0,
             {16'h0003, 16'h0002, 16'h0001}, 1'b0, 4, w);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t7_out_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid          = ~in_valid;
            diff_to_all       = diff_to_all ^ {3{16'h5A5A}};
            z                 = z ^ {3{16'hA5A5}};
            backprop_controll = ~backprop_controll;
        end
        @(negedge clk);
        out_ready = 1'b1;
        // Next transaction offered during the output handshake: exactly one bubble cycle.
        send(8, 4'd1, 1'b1, '0, {3{16'h0100}},
             {16'h0001, 16'h8000, 16'h0000}, '0,
             {16'h0100, 16'h0000, 16'h0000}, 1'b0, 4, w);
        check("t8_bubble_waits", w, 1);
        wait_drain("drain_backpressure");

        // Reset during CALC lane 1: result must be discarded.
        send(9, 4'd1, 1'b0, {3{16'h0200}}, '0, {3{16'h0100}}, '0,
             {3{16'h0200}}, 1'b0, 4, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_delta", delta_out, '0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_in_ready", in_ready, 1'b1);
        check("after_rst_out_valid", out_valid, 1'b0);
        repeat (12) @(negedge clk);

        // Recovery transaction after the reset.
        send(10, 4'd2, 1'b0, {16'h0008, 16'h0010, 16'h0100}, '0,
             {16'h0100, 16'h0100, 16'hFFFF}, '0,
             {16'h0008, 16'h0010, 16'h0020}, 1'b0, 4, w);
        wait_drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
